prim_clock_gate_ctrl: RTL and testbench
=======================================

# prim_clock_gate_ctrl

Sequential enable controller driving the `en_i` input of the generic clock-gating cell for a functional unit. It detects sustained idleness, negotiates a sleep handshake with the unit, and drops the gate enable. On wake it restores the enable and reports readiness after a fixed settle delay. It sits in the always-on clock domain, beside the gating cell it controls.

## Interface
Parameters:
- `IdleCycles`, default 8: consecutive idle cycles required before a sleep request is raised; legal range 1..255.
- `WakeCycles`, default 2: cycles from enable restore to `ready_o`; legal range 1..15.

Ports:
- `clk_i` in 1: free-running, ungated clock, the only clock.
- `rst_i` in 1: synchronous, active-high reset.
- `busy_i` in 1: unit has work in flight.
- `wake_i` in 1: external wake or pending-work request.
- `sleep_ack_i` in 1: unit has quiesced in response to `sleep_req_o`.
- `test_en_i` in 1: scan/test mode; gating is disallowed while it is high.
- `en_o` out 1: clock enable, connected to the gating cell `en_i`.
- `sleep_req_o` out 1: request for the unit to quiesce.
- `ready_o` out 1: unit clock is running and settled.
- `gated_o` out 1: unit clock is stopped.
- `gated_cycles_o` out 32: statistics output, present only with the macro (see Configuration).

## Operation
- All outputs are registered. Reset values: `en_o`=1, `sleep_req_o`=0, `ready_o`=1, `gated_o`=0, `gated_cycles_o`=0. Reset places the FSM in RUN and clears all counters.
- States: RUN, DRAIN, GATED, WAKE.
- **RUN**
  - An idle cycle is one where `busy_i`=0 and `wake_i`=0; each idle cycle increments the 8-bit idle counter.
  - Any non-idle cycle clears the counter.
  - When the counter equals `IdleCycles`-1 and the current cycle is idle, the FSM moves to DRAIN.
- **DRAIN**
  - Outputs: `sleep_req_o`=1, `ready_o`=0, `en_o`=1.
  - `busy_i` or `wake_i` aborts to RUN.
  - Otherwise `sleep_ack_i` moves the FSM to GATED.
  - If `sleep_ack_i` and `wake_i` are both high in the same cycle, wake wins and the FSM goes to RUN.
- **GATED**
  - Outputs: `en_o`=0, `gated_o`=1, `sleep_req_o`=1, `ready_o`=0.
  - `wake_i` or `busy_i` moves the FSM to WAKE.
- **WAKE**
  - Outputs: `en_o`=1, `gated_o`=0, `sleep_req_o`=1, `ready_o`=0.
  - A 4-bit settle counter runs for `WakeCycles` cycles, then the FSM moves to RUN.
  - `wake_i` in this state is ignored.
- On every entry to RUN: `sleep_req_o`=0, `ready_o`=1, idle counter cleared.
- `sleep_ack_i` is ignored outside DRAIN.
- `test_en_i`=1 forces the next state to RUN from any state and holds the idle counter at 0.
- An illegal state encoding recovers to RUN.

## Timing
- Idle to request:
  - RUN is entered at the clock edge after the last non-idle cycle T0; idle cycles are T1..T`IdleCycles`.
  - The FSM enters DRAIN at the clock edge ending cycle T`IdleCycles`.
  - `sleep_req_o` is therefore high from cycle T`IdleCycles`+1.
- Ack to gate: `sleep_ack_i` sampled in cycle t gives `en_o`=0 and `gated_o`=1 in cycle t+1.
- Wake:
  - `wake_i` sampled in cycle t gives `en_o`=1 in cycle t+1.
  - `ready_o`=1 and `sleep_req_o`=0 in cycle t+1+`WakeCycles`.
- Abort: `busy_i` in DRAIN at cycle t gives `sleep_req_o`=0 and `ready_o`=1 at t+1. `en_o` never drops in this path.
- Reset mid-operation, including from GATED, restores the reset values at the next edge; `en_o` returns to 1.

## Configuration
- Macro `PRIM_CG_CTRL_STATS_EN`.
- Defined:
  - `gated_cycles_o` counts cycles with `gated_o`=1.
  - It saturates at 32'hFFFF_FFFF and is cleared only by `rst_i`.
- Undefined: the port is absent and no counter logic is built.

## Structure
- Package `prim_cg_ctrl_pkg` holds:
  - enum `cg_state_e` (RUN, DRAIN, GATED, WAKE; 2-bit);
  - constants `IdleCntW`=8 and `WakeCntW`=4;
  - the statistics counter width of 32.
- One sub-module, `prim_cg_ctrl_stats`: the saturating gated-cycle counter, instantiated only under the macro.

## Test plan
Each scenario uses `IdleCycles`=4, `WakeCycles`=2.
- Reset, then hold `busy_i`=0 from cycle 0: `sleep_req_o` rises at cycle 5. Ack at cycle 7 gives `en_o`=0 and `gated_o`=1 at cycle 8.
- In GATED, pulse `wake_i` at cycle 20: `en_o`=1 at cycle 21; `ready_o`=1 and `sleep_req_o`=0 at cycle 23.
- Raise `busy_i` for 1 cycle after 3 idle cycles: the counter restarts, and `sleep_req_o` stays 0 until 4 further idle cycles have elapsed.
- In DRAIN, drive `sleep_ack_i`=1 and `wake_i`=1 together: the FSM returns to RUN, `en_o` stays 1, and `ready_o`=1 in the next cycle.
- Drive `test_en_i`=1 during GATED: `en_o`=1 and `ready_o`=1 the next cycle. No `sleep_req_o` is raised while `test_en_i` stays high for 100 idle cycles.
- With `PRIM_CG_CTRL_STATS_EN` defined, 10 cycles in GATED give `gated_cycles_o`=10. Forcing the counter to 32'hFFFF_FFFE and staying gated 3 more cycles holds it at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/prim_cg_ctrl_pkg.sv
// Shared types and widths for the clock-gate enable controller.
// Optional gated-cycle statistics are enabled by defining PRIM_CG_CTRL_STATS_EN.
package prim_cg_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } cg_state_e;

    localparam int IdleCntW  = 8;
    localparam int WakeCntW  = 4;
    localparam int StatsCntW = 32;

endpackage

// File: rtl/prim_cg_ctrl_stats.sv
// Saturating counter of cycles spent with the unit clock stopped.
// Only instantiated when PRIM_CG_CTRL_STATS_EN is defined.
module prim_cg_ctrl_stats
    import prim_cg_ctrl_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    output logic [StatsCntW-1:0] cnt_o
);

    logic [StatsCntW-1:0] cnt_q;

    // Holds at all-ones once reached; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prim_clock_gate_ctrl.sv
// Idle-detecting enable controller for a clock-gating cell with sleep handshake.
// Define PRIM_CG_CTRL_STATS_EN to add the gated_cycles_o statistics port.
module prim_clock_gate_ctrl
    import prim_cg_ctrl_pkg::*;
#(
    parameter int IdleCycles = 8,
    parameter int WakeCycles = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 busy_i,
    input  logic                 wake_i,
    input  logic                 sleep_ack_i,
    input  logic                 test_en_i,
    output logic                 en_o,
    output logic                 sleep_req_o,
    output logic                 ready_o,
    output logic                 gated_o
`ifdef PRIM_CG_CTRL_STATS_EN
    ,
    output logic [StatsCntW-1:0] gated_cycles_o
`endif
);

    localparam logic [IdleCntW-1:0] IdleLast = IdleCntW'(IdleCycles - 1);
    localparam logic [WakeCntW-1:0] WakeLast = WakeCntW'(WakeCycles - 1);

    cg_state_e             state_q, state_d;
    logic [IdleCntW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [WakeCntW-1:0]   wake_cnt_q, wake_cnt_d;
    logic                  idle;

    assign idle = !busy_i && !wake_i;

    // Counters default to zero so every state entry starts them cleanly.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        case (state_q)
            RUN: begin
                if (idle) begin
                    if (idle_cnt_q == IdleLast) begin
                        state_d = DRAIN;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (busy_i || wake_i) begin
                    state_d = RUN;
                end else if (sleep_ack_i) begin
                    state_d = GATED;
                end
            end
            GATED: begin
                if (wake_i || busy_i) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                if (wake_cnt_q == WakeLast) begin
                    state_d = RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        if (test_en_i) begin
            state_d    = RUN;
            idle_cnt_d = '0;
            wake_cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so they change together with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            en_o        <= 1'b1;
            sleep_req_o <= 1'b0;
            ready_o     <= 1'b1;
            gated_o     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            en_o        <= (state_d != GATED);
            sleep_req_o <= (state_d != RUN);
            ready_o     <= (state_d == RUN);
            gated_o     <= (state_d == GATED);
        end
    end

`ifdef PRIM_CG_CTRL_STATS_EN
    prim_cg_ctrl_stats u_stats (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (gated_o),
        .cnt_o (gated_cycles_o)
    );
`endif

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// Self-checking bench: directed handshake scenarios plus random stimulus,
// all checked every cycle against a behavioural model of the controller.
module tb_prim_clock_gate_ctrl;

    localparam int IDLE = 4;
    localparam int WAKE = 2;

    logic clk_i = 1'b0;
    logic rst_i, busy_i, wake_i, sleep_ack_i, test_en_i;
    logic en_o, sleep_req_o, ready_o, gated_o;
`ifdef PRIM_CG_CTRL_STATS_EN
    logic [31:0] gated_cycles_o;
`endif

    int tests = 0;
    int errors = 0;

    int          m_idle = 0;
    int          m_settle = 0;
    bit          m_drain = 0;
    bit          m_gated = 0;
    bit          m_valid = 0;
    bit          stats_poke = 0;
    logic [31:0] m_stats = '0;

    always #5 clk_i = ~clk_i;

    prim_clock_gate_ctrl #(
        .IdleCycles (IDLE),
        .WakeCycles (WAKE)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .busy_i      (busy_i),
        .wake_i      (wake_i),
        .sleep_ack_i (sleep_ack_i),
        .test_en_i   (test_en_i),
        .en_o        (en_o),
        .sleep_req_o (sleep_req_o),
        .ready_o     (ready_o),
        .gated_o     (gated_o)
`ifdef PRIM_CG_CTRL_STATS_EN
        ,
        .gated_cycles_o (gated_cycles_o)
`endif
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase flags plus plain counters of idle cycles and settle cycles left.
    always @(posedge clk_i) begin
        if (rst_i) begin
            m_idle   <= 0;
            m_settle <= 0;
            m_drain  <= 1'b0;
            m_gated  <= 1'b0;
            m_stats  <= '0;
            m_valid  <= 1'b1;
        end else begin
            if (stats_poke)
                m_stats <= 32'hFFFF_FFFE + {31'b0, m_gated};
            else if (m_gated && m_stats != 32'hFFFF_FFFF)
                m_stats <= m_stats + 1;
            if (test_en_i) begin
                m_idle   <= 0;
                m_settle <= 0;
                m_drain  <= 1'b0;
                m_gated  <= 1'b0;
            end else if (m_settle > 0) begin
                m_settle <= m_settle - 1;
            end else if (m_gated) begin
                if (wake_i || busy_i) begin
                    m_gated  <= 1'b0;
                    m_settle <= WAKE;
                end
            end else if (m_drain) begin
                if (busy_i || wake_i) begin
                    m_drain <= 1'b0;
                end else if (sleep_ack_i) begin
                    m_drain <= 1'b0;
                    m_gated <= 1'b1;
                end
            end else if (busy_i || wake_i) begin
                m_idle <= 0;
            end else if (m_idle + 1 == IDLE) begin
                m_drain <= 1'b1;
                m_idle  <= 0;
            end else begin
                m_idle <= m_idle + 1;
            end
        end
    end

    always @(negedge clk_i) begin
        if (m_valid) begin
            check_bit("model_en_o", en_o, !m_gated);
            check_bit("model_gated_o", gated_o, m_gated);
            check_bit("model_sleep_req_o", sleep_req_o, m_drain || m_gated || (m_settle > 0));
            check_bit("model_ready_o", ready_o, !(m_drain || m_gated || (m_settle > 0)));
`ifdef PRIM_CG_CTRL_STATS_EN
            check_word("model_gated_cycles_o", gated_cycles_o, m_stats);
`endif
        end
    end

    task automatic apply_stimulus(input logic b, input logic w, input logic a, input logic t);
        busy_i      = b;
        wake_i      = w;
        sleep_ack_i = a;
        test_en_i   = t;
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_to_drain();
        apply_stimulus(0, 0, 0, 0);
        for (int i = 1; i < IDLE; i++) begin
            step();
            check_bit("idle_no_req", sleep_req_o, 1'b0);
        end
        step();
        check_bit("drain_req", sleep_req_o, 1'b1);
        check_bit("drain_en", en_o, 1'b1);
    endtask

    initial begin
        rst_i = 1'b1;
        apply_stimulus(0, 0, 0, 0);
        @(negedge clk_i);
        step();
        check_bit("rst_en_o", en_o, 1'b1);
        check_bit("rst_sleep_req_o", sleep_req_o, 1'b0);
        check_bit("rst_ready_o", ready_o, 1'b1);
        check_bit("rst_gated_o", gated_o, 1'b0);
        rst_i = 1'b0;

        // Idle from reset, then ack after one extra DRAIN cycle.
        idle_to_drain();
        check_bit("drain_ready", ready_o, 1'b0);
        step();
        check_bit("drain_hold", sleep_req_o, 1'b1);
        apply_stimulus(0, 0, 1, 0);
        step();
        check_bit("ack_en_o", en_o, 1'b0);
        check_bit("ack_gated_o", gated_o, 1'b1);
        apply_stimulus(0, 0, 0, 0);
`ifdef PRIM_CG_CTRL_STATS_EN
        check_word("stats_start", gated_cycles_o, 32'd0);
        repeat (10) step();
        check_word("stats_ten", gated_cycles_o, 32'd10);
        #2;
        force dut.u_stats.cnt_q = 32'hFFFF_FFFE;
        release dut.u_stats.cnt_q;
        stats_poke = 1'b1;
        step();
        stats_poke = 1'b0;
        repeat (2) step();
        check_word("stats_saturate", gated_cycles_o, 32'hFFFF_FFFF);
`else
        repeat (10) step();
`endif
        check_bit("gated_hold", en_o, 1'b0);

        // Wake pulse: enable at once, ready after the settle delay.
        apply_stimulus(0, 1, 0, 0);
        step();
        check_bit("wake_en_o", en_o, 1'b1);
        check_bit("wake_gated_o", gated_o, 1'b0);
        check_bit("wake_ready_early", ready_o, 1'b0);
        apply_stimulus(0, 0, 0, 0);
        step();
        check_bit("wake_settling", ready_o, 1'b0);
        step();
        check_bit("wake_ready", ready_o, 1'b1);
        check_bit("wake_req_clear", sleep_req_o, 1'b0);

        // A busy cycle after three idle cycles restarts the count.
        repeat (3) step();
        check_bit("restart_pre", sleep_req_o, 1'b0);
        apply_stimulus(1, 0, 0, 0);
        step();
        idle_to_drain();

        // Busy in DRAIN aborts without ever dropping the enable.
        apply_stimulus(1, 0, 0, 0);
        step();
        check_bit("abort_req", sleep_req_o, 1'b0);
        check_bit("abort_ready", ready_o, 1'b1);
        check_bit("abort_en", en_o, 1'b1);

        // Ack and wake together: wake wins.
        idle_to_drain();
        apply_stimulus(0, 1, 1, 0);
        step();
        check_bit("ackwake_en", en_o, 1'b1);
        check_bit("ackwake_ready", ready_o, 1'b1);
        check_bit("ackwake_req", sleep_req_o, 1'b0);

        // Test mode out of GATED, then a long idle stretch with no request.
        idle_to_drain();
        apply_stimulus(0, 0, 1, 0);
        step();
        check_bit("pre_test_gated", gated_o, 1'b1);
        apply_stimulus(0, 0, 0, 1);
        step();
        check_bit("test_en_o", en_o, 1'b1);
        check_bit("test_ready_o", ready_o, 1'b1);
        for (int i = 0; i < 100; i++) begin
            step();
            check_bit("test_no_req", sleep_req_o, 1'b0);
        end
        apply_stimulus(0, 0, 0, 0);

        // Random traffic, including occasional reset and test mode.
        for (int i = 0; i < 4000; i++) begin
            rst_i = ($urandom_range(199) == 0);
            apply_stimulus($urandom_range(5) == 0, $urandom_range(9) == 0,
                           $urandom_range(2) == 0, $urandom_range(49) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
